fp_except_pack_pipe: RTL

- Parametrised, registered successor to the combinational FP result packer / exception checker.
- Takes the unpacked adder/multiplier/divider result (sign, exponent, untruncated significand with hidden and G/R/S bits, carry, special-case code) through a valid/ready handshake.
- Emits the packed IEEE-754 word plus a per-result error code after one register stage.
- Accumulates sticky RISC-V-style exception flags (NV DZ OF UF NX) until software clears them; sits between the FP datapath and the FP register file / fcsr.

---
 rtl/fp_pkg.sv | 29 ++
 rtl/fp_pack_classify.sv | 87 ++++++++
 rtl/fp_except_pack_pipe.sv | 110 +++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared FP result types: operand-checker special-case codes, result error codes
// and the bit positions of the sticky {NV,DZ,OF,UF,NX} exception flags.
package fp_pkg;

    typedef enum logic [2:0] {
        NO_ERR      = 3'd0,
        ZERO_OP_ERR = 3'd1,
        INF_ERR     = 3'd2,
        NAN_ERR     = 3'd3,
        ZERO_ERR    = 3'd4,
        DIVZ_ERR    = 3'd5
    } i_err_t;

    typedef enum logic [2:0] {
        NONE      = 3'd0,
        INVALID   = 3'd1,
        DIVZERO   = 3'd2,
        OVERFLOW  = 3'd3,
        UNDERFLOW = 3'd4,
        INEXACT   = 3'd5
    } o_err_t;

    localparam int FLG_NV = 4;
    localparam int FLG_DZ = 3;
    localparam int FLG_OF = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_NX = 0;

endpackage

// File: rtl/fp_pack_classify.sv
// Combinational packer: selects the IEEE-754 word for the special-case code,
// patches carry-overflow into infinity and derives the error code and flag events.
module fp_pack_classify
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int SIG_W = 23,
    parameter int FW    = EXP_W + SIG_W + 1
) (
    input  logic              sign_i,
    input  logic [EXP_W-1:0]  exp_i,
    input  logic [SIG_W+3:0]  sig_untrunc_i,
    input  logic              carry_i,
    input  logic [FW-2:0]     nz_op_i,
    input  i_err_t            err_i,
    output logic [FW-1:0]     fp_word,
    output o_err_t            err_code,
    output logic [4:0]        events
);

    localparam logic [EXP_W-1:0] EXP_ONES = '1;

    logic              p_sign;
    logic [EXP_W-1:0]  p_exp;
    logic [SIG_W-1:0]  p_frac;
    logic [SIG_W-1:0]  frac_raw;
    logic              grs;
    logic              unused_hidden;

    // The hidden bit is implied by the exponent field and never stored.
    assign unused_hidden = sig_untrunc_i[SIG_W+3];
    assign frac_raw      = sig_untrunc_i[SIG_W+2:3];
    assign grs           = |sig_untrunc_i[2:0];

    always_comb begin
        p_sign = sign_i;
        p_exp  = exp_i;
        p_frac = frac_raw;
        case (err_i)
            ZERO_OP_ERR:       {p_exp, p_frac} = nz_op_i;
            INF_ERR, DIVZ_ERR: begin p_exp = EXP_ONES; p_frac = '0; end
            NAN_ERR: begin
                p_sign = 1'b0;
                p_exp  = EXP_ONES;
                p_frac = {1'b1, {(SIG_W-1){1'b0}}};
            end
            ZERO_ERR: begin p_sign = 1'b0; p_exp = '0; p_frac = '0; end
            default: ;
        endcase
        // A normalisation carry into the all-ones exponent means infinity, not NaN.
        if (err_i != NAN_ERR && carry_i && p_exp == EXP_ONES && p_frac != '0)
            p_frac = '0;
    end

    assign fp_word = {p_sign, p_exp, p_frac};

    always_comb begin
        if (err_i == DIVZ_ERR)                        err_code = DIVZERO;
        else if (p_exp == EXP_ONES && p_frac == '0)   err_code = OVERFLOW;
        else if (p_exp == EXP_ONES)                   err_code = INVALID;
        else if (p_exp == '0 && p_frac != '0)         err_code = UNDERFLOW;
        else if (err_i == NO_ERR && grs)              err_code = INEXACT;
        else                                          err_code = NONE;
    end

    // An infinity that arrived as an operand is reported but did not overflow here.
    always_comb begin
        events = '0;
        case (err_code)
            INVALID: events[FLG_NV] = 1'b1;
            DIVZERO: events[FLG_DZ] = 1'b1;
            OVERFLOW: begin
                if (err_i != INF_ERR || carry_i) begin
                    events[FLG_OF] = 1'b1;
                    events[FLG_NX] = 1'b1;
                end
            end
            UNDERFLOW: begin
                events[FLG_UF] = 1'b1;
                events[FLG_NX] = grs;
            end
            INEXACT: events[FLG_NX] = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/fp_except_pack_pipe.sv
// Registered FP result packer with valid/ready handshake and sticky exception flags.
// Define FP_EXC_COUNT_EN to add five 16-bit saturating per-flag event counters.
module fp_except_pack_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int SIG_W = 23,
    parameter int FW    = EXP_W + SIG_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign_i,
    input  logic [EXP_W-1:0]  exp_i,
    input  logic [SIG_W+3:0]  sig_untrunc_i,
    input  logic              carry_i,
    input  logic [FW-2:0]     nz_op_i,
    input  i_err_t            err_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FW-1:0]     fp_out,
    output o_err_t            err_o,
    output logic [4:0]        fflags_o,
    input  logic              flags_clr
`ifdef FP_EXC_COUNT_EN
    ,
    output logic [15:0]       cnt_nv_o,
    output logic [15:0]       cnt_dz_o,
    output logic [15:0]       cnt_of_o,
    output logic [15:0]       cnt_uf_o,
    output logic [15:0]       cnt_nx_o
`endif
);

    logic [FW-1:0] fp_word;
    o_err_t        err_code;
    logic [4:0]    events;
    logic [4:0]    ev_q;
    logic          load;
    logic          drain;

    fp_pack_classify #(
        .EXP_W (EXP_W),
        .SIG_W (SIG_W),
        .FW    (FW)
    ) u_classify (
        .sign_i        (sign_i),
        .exp_i         (exp_i),
        .sig_untrunc_i (sig_untrunc_i),
        .carry_i       (carry_i),
        .nz_op_i       (nz_op_i),
        .err_i         (err_i),
        .fp_word       (fp_word),
        .err_code      (err_code),
        .events        (events)
    );

    assign in_ready = !out_valid || out_ready;
    assign load     = in_valid && in_ready;
    assign drain    = out_valid && out_ready;

    // Event bits travel with the result so flags update only when it is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            fp_out    <= '0;
            err_o     <= NONE;
            ev_q      <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            fp_out    <= fp_word;
            err_o     <= err_code;
            ev_q      <= events;
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fflags_o <= '0;
        else if (flags_clr || drain)
            fflags_o <= (flags_clr ? 5'b0 : fflags_o) | (drain ? ev_q : 5'b0);
    end

`ifdef FP_EXC_COUNT_EN
    logic [15:0] cnt_q [5];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (flags_clr)
                    cnt_q[i] <= (drain && ev_q[i]) ? 16'd1 : 16'd0;
                else if (drain && ev_q[i] && cnt_q[i] != 16'hFFFF)
                    cnt_q[i] <= cnt_q[i] + 16'd1;
            end
        end
    end

    assign cnt_nv_o = cnt_q[FLG_NV];
    assign cnt_dz_o = cnt_q[FLG_DZ];
    assign cnt_of_o = cnt_q[FLG_OF];
    assign cnt_uf_o = cnt_q[FLG_UF];
    assign cnt_nx_o = cnt_q[FLG_NX];
`endif

endmodule
